polyphase_halfband_interp: RTL and testbench

- Two-phase polyphase halfband interpolator, upsample by 2. The transmit-side counterpart of the halfband decimator.
- Each accepted input sample produces two output samples:
  - phase 0: the output of the 2K-tap symmetric FIR branch, computed on one time-multiplexed MAC with a pre-adder.
  - phase 1: the centre-tap branch, which is a pure delay of the input (gain 1).
- Sits ahead of the DAC/upconversion path. Valid/ready on both sides.

---
 rtl/polyphase_halfband_interp.sv | 153 +++++++++++++++
 tb/tb_polyphase_halfband_interp.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/polyphase_halfband_interp.sv
// Two-phase halfband interpolator (x2): phase 0 is the symmetric FIR branch on one
// time-multiplexed pre-add MAC, phase 1 is the centre-tap branch (pure delay).
module polyphase_halfband_interp #(
    parameter int unsigned SAMPLE_WIDTH = 16,
    parameter int unsigned COEF_WIDTH   = 16,
    parameter int unsigned K            = 8,
    parameter logic signed [COEF_WIDTH-1:0] COEFS [K] = '{
        -16'sd41, 16'sd111, -16'sd262, 16'sd543, -16'sd1024, 16'sd1850, -16'sd3504, 16'sd18711
    }
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    valid_in,
    output logic                    ready_in,
    input  logic [SAMPLE_WIDTH-1:0] data_in,
    output logic                    valid_out,
    input  logic                    ready_out,
    output logic [SAMPLE_WIDTH-1:0] data_out,
    output logic                    phase_out
);

    localparam int unsigned TW = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned IW = TW + 1;
    localparam int unsigned PW = SAMPLE_WIDTH + COEF_WIDTH + 1;
    localparam int unsigned AW = PW + $clog2(K);

    localparam logic [TW-1:0] LastTap = TW'(K - 1);
    localparam logic [IW-1:0] LastIdx = IW'(2 * K - 1);
    localparam logic signed [AW-1:0] RoundBias = {{(AW-1){1'b0}}, 1'b1} << (COEF_WIDTH - 2);
    localparam logic signed [AW-1:0] SatMax =
        {{(AW-SAMPLE_WIDTH+1){1'b0}}, {(SAMPLE_WIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] SatMin = ~SatMax;

    typedef enum logic [1:0] {StIdle, StMac, StOut0, StOut1} state_e;

    state_e state_q, state_d;

    logic signed [SAMPLE_WIDTH-1:0] x_q [2*K];
    logic [TW-1:0]                  tap_q;
    logic [IW-1:0]                  tap_ext;
    logic signed [AW-1:0]           acc_q;
    logic signed [AW-1:0]           acc_sum;
    logic signed [AW-1:0]           rounded;
    logic signed [SAMPLE_WIDTH-1:0] x_near;
    logic signed [SAMPLE_WIDTH-1:0] x_far;
    logic signed [COEF_WIDTH-1:0]   coef;
    logic signed [SAMPLE_WIDTH:0]   pre_add;
    logic signed [PW-1:0]           product;
    logic signed [SAMPLE_WIDTH-1:0] sat_val;
    logic [SAMPLE_WIDTH-1:0]        data_q;
    logic                           valid_q;
    logic                           phase_q;
    logic                           ready_q;
    logic                           accept;
    logic                           last_tap;

    assign accept   = (state_q == StIdle) && ready_q && valid_in;
    assign last_tap = (tap_q == LastTap);

    // Pre-adder folds the symmetric pair x[j] + x[2K-1-j] before the single multiply.
    assign tap_ext = {1'b0, tap_q};
    assign x_near  = x_q[tap_ext];
    assign x_far   = x_q[LastIdx - tap_ext];
    assign coef    = COEFS[tap_q];
    assign pre_add = $signed({x_near[SAMPLE_WIDTH-1], x_near})
                   + $signed({x_far[SAMPLE_WIDTH-1], x_far});
    assign product = $signed({{COEF_WIDTH{pre_add[SAMPLE_WIDTH]}}, pre_add})
                   * $signed({{(SAMPLE_WIDTH+1){coef[COEF_WIDTH-1]}}, coef});
    assign acc_sum = acc_q + $signed({{(AW-PW){product[PW-1]}}, product});

    // Round half up on the final sum so the registered output lands as OUT0 is entered.
    assign rounded = (acc_sum + RoundBias) >>> (COEF_WIDTH - 1);

    always_comb begin
        sat_val = rounded[SAMPLE_WIDTH-1:0];
        if (rounded > SatMax) begin
            sat_val = SatMax[SAMPLE_WIDTH-1:0];
        end else if (rounded < SatMin) begin
            sat_val = SatMin[SAMPLE_WIDTH-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) state_d = StMac;
            StMac:  if (last_tap) state_d = StOut0;
            StOut0: if (ready_out) state_d = StOut1;
            StOut1: if (ready_out) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == StIdle);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2 * K; i++) begin
                x_q[i] <= '0;
            end
        end else if (accept) begin
            for (int i = 2 * K - 1; i > 0; i--) begin
                x_q[i] <= x_q[i-1];
            end
            x_q[0] <= $signed(data_in);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tap_q   <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            phase_q <= 1'b0;
        end else begin
            if (accept) begin
                tap_q <= '0;
            end
            if (state_q == StMac) begin
                acc_q <= acc_sum;
                tap_q <= last_tap ? '0 : tap_q + 1'b1;
                if (last_tap) begin
                    data_q  <= sat_val;
                    valid_q <= 1'b1;
                    phase_q <= 1'b0;
                end
            end
            if ((state_q == StOut0) && ready_out) begin
                data_q  <= x_q[K-1];
                phase_q <= 1'b1;
            end
            if ((state_q == StOut1) && ready_out) begin
                valid_q <= 1'b0;
                acc_q   <= '0;
            end
        end
    end

    assign ready_in  = ready_q;
    assign valid_out = valid_q;
    assign data_out  = data_q;
    assign phase_out = phase_q;

endmodule

// File: tb/tb_polyphase_halfband_interp.sv
// Directed bench for polyphase_halfband_interp: scoreboard of expected phase-0/phase-1
// outputs filled from spec tables or a reference model as inputs are accepted.
module tb_polyphase_halfband_interp;

    localparam int K = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        valid_in = 1'b0;
    logic        ready_in;
    logic [15:0] data_in = '0;
    logic        valid_out;
    logic        ready_out = 1'b0;
    logic [15:0] data_out;
    logic        phase_out;

    polyphase_halfband_interp dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .data_in   (data_in),
        .valid_out (valid_out),
        .ready_out (ready_out),
        .data_out  (data_out),
        .phase_out (phase_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        ph;
        logic [15:0] d;
    } exp_t;

    exp_t sbq[$];
    int   passed = 0;
    int   failed = 0;
    int   total  = 0;
    int   xm [16];
    int   coef [8] = '{-41, 111, -262, 543, -1024, 1850, -3504, 18711};
    int   imp0 [16] = '{-20, 56, -131, 272, -512, 925, -1752, 9356,
                        9356, -1752, 925, -512, 272, -131, 56, -20};
    int   desired [16];

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_p0();
        longint acc = 0;
        for (int j = 0; j < K; j++) begin
            acc += longint'(coef[j]) * longint'(xm[j] + xm[2*K-1-j]);
        end
        acc = (acc + 64'sd16384) >>> 15;
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
        return int'(acc);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 2 * K; i++) xm[i] = 0;
        sbq.delete();
    endtask

    // Drive one sample (called at a negedge); returns at the negedge after the transfer.
    task automatic send(input int s, input bit use_given, input int e0, input int e1);
        int   n;
        exp_t e;
        n = 0;
        valid_in = 1'b1;
        data_in  = 16'(s);
        while (ready_in !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("in_accept", ready_in, 1);
        @(negedge clk);
        valid_in = 1'b0;
        for (int i = 2 * K - 1; i > 0; i--) xm[i] = xm[i-1];
        xm[0] = s;
        e.ph = 1'b0;
        e.d  = use_given ? 16'(e0) : 16'(model_p0());
        sbq.push_back(e);
        e.ph = 1'b1;
        e.d  = use_given ? 16'(e1) : 16'(xm[K-1]);
        sbq.push_back(e);
    endtask

    // Collect the phase-0/phase-1 pair with ready_out high.
    task automatic recv(input int lat0);
        int   n;
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            n = 0;
            while (valid_out !== 1'b1 && n < 200) begin
                @(negedge clk);
                n++;
            end
            check(k == 0 ? "latency_p0" : "latency_p1", n, k == 0 ? lat0 : 0);
            if (sbq.size() == 0) begin
                check("scoreboard_empty", sbq.size(), 1);
                return;
            end
            e = sbq.pop_front();
            check("phase", phase_out, e.ph);
            check("data", $signed(data_out), $signed(e.d));
            @(negedge clk);
        end
        check("ready_after_pair", ready_in, 1);
    endtask

    task automatic impulse_run();
        for (int m = 0; m < 16; m++) begin
            send(m == 0 ? 16384 : 0, 1'b1, imp0[m], m == 7 ? 16384 : 0);
            recv(K);
        end
    endtask

    initial begin
        int n;
        int held;
        exp_t e;

        // Reset with random stimulus on every input.
        model_clear();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            valid_in  = 1'($urandom);
            ready_out = 1'($urandom);
            data_in   = 16'($urandom);
            check("rst_valid_out", valid_out, 0);
            check("rst_data_out", data_out, 0);
            check("rst_ready_in", ready_in, 0);
            check("rst_phase_out", phase_out, 0);
        end
        valid_in  = 1'b0;
        ready_out = 1'b1;
        reset_n   = 1'b1;
        @(negedge clk);
        check("ready_after_reset", ready_in, 1);

        impulse_run();

        // DC: every output settles to 1000 once the line is full.
        for (int m = 0; m < 32; m++) begin
            send(1000, m >= 15, 1000, 1000);
            recv(K);
        end

        // Saturation: taps aligned with coefficient signs, then mirrored.
        for (int p = 0; p < 2 * K; p++) begin
            desired[p] = coef[p < K ? p : 2*K-1-p] > 0 ? 32767 : -32768;
        end
        for (int i = 0; i < 2 * K; i++) begin
            send(desired[2*K-1-i], i == 2*K-1, 32767, desired[K-1]);
            recv(K);
        end
        for (int i = 0; i < 2 * K; i++) begin
            send(desired[2*K-1-i] > 0 ? -32768 : 32767, i == 2*K-1, -32768,
                 desired[K-1] > 0 ? -32768 : 32767);
            recv(K);
        end

        // A few random samples against the model.
        for (int i = 0; i < 8; i++) begin
            send($signed(16'($urandom)), 1'b0, 0, 0);
            recv(K);
        end

        // Backpressure during OUT0 with a new input held on valid_in.
        send(-7777, 1'b0, 0, 0);
        ready_out = 1'b0;
        n = 0;
        while (valid_out !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("bp_latency", n, K);
        held     = 4321;
        valid_in = 1'b1;
        data_in  = 16'(held);
        e        = sbq[0];
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("bp_valid_out", valid_out, 1);
            check("bp_data_stable", $signed(data_out), $signed(e.d));
            check("bp_phase_stable", phase_out, e.ph);
            check("bp_ready_in", ready_in, 0);
        end
        ready_out = 1'b1;
        recv(0);
        send(held, 1'b0, 0, 0);
        recv(K);

        // Reset on the 3rd MAC cycle; the line must be empty for the next impulse.
        send(12345, 1'b0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst_valid_out", valid_out, 0);
        check("midrst_ready_in", ready_in, 0);
        check("midrst_data_out", data_out, 0);
        model_clear();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("ready_after_midrst", ready_in, 1);
        impulse_run();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
